// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for a single fixed-latency memory port
//
// Purpose: grants the memory port to master 0 (control unit) or master 1
// (DMA/debug loader), holds MEM_READ/MEM_WRITE for ACCESS_CYCLES cycles,
// returns read data and a one-cycle DONE pulse to the winner.
// Optional macro MEM_ARB_FIXED_PRIO_EN: when defined, master 0 always wins
// ties; when undefined, ties are broken round-robin.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   Mx_REQ/WE/ADDR/WDATA     requester inputs (x = 0, 1), latched at grant
//   Mx_GNT/DONE/RDATA        grant, completion pulse, last read data
//   MEM_ADDR/READ/WRITE/WDATA/RDATA  memory-side port
//   BUSY                     arbiter not idle
module mem_bus_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 26,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  M0_REQ,
    input  logic                  M0_WE,
    input  logic [ADDR_WIDTH-1:0] M0_ADDR,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    output logic                  M0_GNT,
    output logic                  M0_DONE,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    input  logic                  M1_REQ,
    input  logic                  M1_WE,
    input  logic [ADDR_WIDTH-1:0] M1_ADDR,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    output logic                  M1_GNT,
    output logic                  M1_DONE,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            owner;      // master that currently owns the bus
    logic            any_req;
    logic            winner;     // 0 = master 0, 1 = master 1
    logic            win_we;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic            last;       // master served most recently
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Arbitration and next-state logic
    always_comb begin
        any_req = M0_REQ | M1_REQ;
`ifdef MEM_ARB_FIXED_PRIO_EN
        winner = ~M0_REQ;
`else
        // On a tie the master that was not served last wins.
        winner = (M0_REQ & M1_REQ) ? ~last : M1_REQ;
`endif
        win_we = winner ? M1_WE : M0_WE;

        state_next = state;
        case (state)
            S_IDLE:   if (any_req) state_next = S_ACCESS;
            S_ACCESS: if (cnt == '0) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            M0_GNT    <= 1'b0;
            M1_GNT    <= 1'b0;
            M0_DONE   <= 1'b0;
            M1_DONE   <= 1'b0;
            M0_RDATA  <= '0;
            M1_RDATA  <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            BUSY      <= 1'b0;
            cnt       <= '0;
            owner     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last      <= winner;
`endif
                        MEM_ADDR  <= winner ? M1_ADDR : M0_ADDR;
                        MEM_WDATA <= winner ? M1_WDATA : M0_WDATA;
                        MEM_READ  <= ~win_we;
                        MEM_WRITE <= win_we;
                        M0_GNT    <= ~winner;
                        M1_GNT    <= winner;
                        BUSY      <= 1'b1;
                        cnt       <= CW'(ACCESS_CYCLES - 1);
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        // MEM_RDATA is valid only in this final access cycle.
                        if (MEM_READ) begin
                            if (owner) M1_RDATA <= MEM_RDATA;
                            else       M0_RDATA <= MEM_RDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        M0_DONE   <= ~owner;
                        M1_DONE   <= owner;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    M0_GNT  <= 1'b0;
                    M1_GNT  <= 1'b0;
                    M0_DONE <= 1'b0;
                    M1_DONE <= 1'b0;
                    BUSY    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
